// File: rtl/mcu_mbox_sram_zeroize.sv
// mcu_mbox_sram_zeroize: sits between mcu_mbox and the mailbox SRAM.
// Passes upstream SRAM requests through while idle; on mailbox release it
// walks words 0..end writing all-zero {ecc, data} and then pulses zero_done.
// Optional feature macro: MCU_MBOX_ZERO_PREEMPT_EN (upstream preempts the walker).
module mcu_mbox_sram_zeroize #(
    parameter int unsigned MCU_MBOX_SRAM_SIZE_KB = 512,
    localparam int unsigned DEPTH  = MCU_MBOX_SRAM_SIZE_KB * 1024 / 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              zero_start,
    input  logic [ADDR_W-1:0] zero_end_addr,
    input  logic              up_cs,
    input  logic              up_we,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [38:0]       up_wdata,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [38:0]       sram_wdata,
    output logic              zero_in_progress,
    output logic              zero_done,
    output logic              up_blocked
);

    localparam int unsigned DATA_W = 39;

`ifdef MCU_MBOX_ZERO_PREEMPT_EN
    localparam bit PREEMPT_EN = 1'b1;
`else
    localparam bit PREEMPT_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ZERO = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [ADDR_W-1:0] end_q,   end_d;

    // State, walk counter and latched end address; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
        end
    end

    // Next-state logic and SRAM port muxing (passthrough is zero-latency).
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        end_d            = end_q;
        sram_cs          = up_cs;
        sram_we          = up_we;
        sram_addr        = up_addr;
        sram_wdata       = up_wdata;
        zero_in_progress = 1'b0;
        zero_done        = 1'b0;
        up_blocked       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (zero_start) begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                    // Clamp so a non-power-of-two SRAM is never walked past its last word.
                    end_d   = (32'(zero_end_addr) >= DEPTH) ? LAST_ADDR : zero_end_addr;
                end
            end
            ST_ZERO: begin
                zero_in_progress = 1'b1;
                if (!(PREEMPT_EN && up_cs)) begin
                    // Zero data encodes to zero ECC, so the whole word is simply 0.
                    sram_cs    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = cnt_q;
                    sram_wdata = DATA_W'(0);
                    up_blocked = up_cs;
                    if (cnt_q == end_q) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                zero_in_progress = 1'b1;
                zero_done        = 1'b1;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs read as zero while reset is held.
        if (!rst_b) begin
            sram_cs          = 1'b0;
            sram_we          = 1'b0;
            sram_addr        = '0;
            sram_wdata       = '0;
            zero_in_progress = 1'b0;
            zero_done        = 1'b0;
            up_blocked       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcu_mbox_sram_zeroize.sv
// Self-checking bench for mcu_mbox_sram_zeroize (768-word SRAM, exercises the clamp).
module tb_mcu_mbox_sram_zeroize;

    localparam int unsigned KB    = 3;
    localparam int unsigned DEPTH = KB * 1024 / 4;
    localparam int unsigned AW    = $clog2(DEPTH);

`ifdef MCU_MBOX_ZERO_PREEMPT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    typedef struct {
        logic          zs;
        logic [AW-1:0] zea;
        logic          ucs, uwe;
        logic [AW-1:0] ua;
        logic [38:0]   uwd;
        logic          ecs, ewe;
        logic [AW-1:0] ea;
        logic [38:0]   ewd;
        logic          ezip, edone, eblk;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          zero_start;
    logic [AW-1:0] zero_end_addr;
    logic          up_cs, up_we;
    logic [AW-1:0] up_addr;
    logic [38:0]   up_wdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [38:0]   sram_wdata;
    logic          zero_in_progress, zero_done, up_blocked;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tbl[10];

    mcu_mbox_sram_zeroize #(.MCU_MBOX_SRAM_SIZE_KB(KB)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .zero_start       (zero_start),
        .zero_end_addr    (zero_end_addr),
        .up_cs            (up_cs),
        .up_we            (up_we),
        .up_addr          (up_addr),
        .up_wdata         (up_wdata),
        .sram_cs          (sram_cs),
        .sram_we          (sram_we),
        .sram_addr        (sram_addr),
        .sram_wdata       (sram_wdata),
        .zero_in_progress (zero_in_progress),
        .zero_done        (zero_done),
        .up_blocked       (up_blocked)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic zs, input logic [AW-1:0] zea,
                                input logic ucs, input logic uwe, input logic [AW-1:0] ua,
                                input logic [38:0] uwd,
                                input logic ecs, input logic ewe, input logic [AW-1:0] ea,
                                input logic [38:0] ewd,
                                input logic ezip, input logic edone, input logic eblk);
        vec_t v;
        v.zs = zs; v.zea = zea; v.ucs = ucs; v.uwe = uwe; v.ua = ua; v.uwd = uwd;
        v.ecs = ecs; v.ewe = ewe; v.ea = ea; v.ewd = ewd;
        v.ezip = ezip; v.edone = edone; v.eblk = eblk;
        return v;
    endfunction

    task automatic drive(input logic zs, input logic [AW-1:0] zea, input logic ucs,
                         input logic uwe, input logic [AW-1:0] ua, input logic [38:0] uwd);
        zero_start    = zs;
        zero_end_addr = zea;
        up_cs         = ucs;
        up_we         = uwe;
        up_addr       = ua;
        up_wdata      = uwd;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic cs, input logic we, input logic [AW-1:0] a,
                       input logic [38:0] wd, input logic zip, input logic dn, input logic blk);
        logic [AW+43:0] act, exp;
        act = {sram_cs, sram_we, sram_addr, sram_wdata, zero_in_progress, zero_done, up_blocked};
        exp = {cs, we, a, wd, zip, dn, blk};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cs=%b we=%b addr=%0d wdata=%h zip=%b done=%b blk=%b, required cs=%b we=%b addr=%0d wdata=%h zip=%b done=%b blk=%b",
                     nm, sram_cs, sram_we, sram_addr, sram_wdata, zero_in_progress, zero_done, up_blocked,
                     cs, we, a, wd, zip, dn, blk);
        end
    endtask

    initial begin
        logic [38:0]   wd_a, wd_b, wd_c;
        logic [AW-1:0] all1;
        wd_a = 39'h12_3456_789A;
        wd_b = 39'h00_0000_0055;
        wd_c = 39'h7F_FFFF_FFFF;
        all1 = '1;

        // Walk end=3 starting at row 2 (T); upstream hit at T+2, redundant zero_start at T+3.
        tbl[0] = mk(0, 0,  1, 1, 5,  wd_a,  1, 1, 5,  wd_a,  0, 0, 0);
        tbl[1] = mk(0, 0,  1, 0, 7,  0,     1, 0, 7,  0,     0, 0, 0);
        tbl[2] = mk(1, 3,  1, 1, 9,  wd_b,  1, 1, 9,  wd_b,  0, 0, 0);
        tbl[3] = mk(0, 0,  0, 0, 0,  0,     1, 1, 0,  0,     1, 0, 0);
        if (!PE) begin
            tbl[4] = mk(0, 0,  1, 1, 20, wd_c,  1, 1, 1,  0,  1, 0, 1);
            tbl[5] = mk(1, 10, 0, 0, 0,  0,     1, 1, 2,  0,  1, 0, 0);
            tbl[6] = mk(0, 0,  0, 0, 0,  0,     1, 1, 3,  0,  1, 0, 0);
            tbl[7] = mk(0, 0,  0, 0, 0,  0,     0, 0, 0,  0,  1, 1, 0);
            tbl[8] = mk(0, 0,  0, 0, 0,  0,     0, 0, 0,  0,  0, 0, 0);
        end else begin
            tbl[4] = mk(0, 0,  1, 1, 20, wd_c,  1, 1, 20, wd_c, 1, 0, 0);
            tbl[5] = mk(1, 10, 0, 0, 0,  0,     1, 1, 1,  0,  1, 0, 0);
            tbl[6] = mk(0, 0,  0, 0, 0,  0,     1, 1, 2,  0,  1, 0, 0);
            tbl[7] = mk(0, 0,  0, 0, 0,  0,     1, 1, 3,  0,  1, 0, 0);
            tbl[8] = mk(0, 0,  0, 0, 0,  0,     0, 0, 0,  0,  1, 1, 0);
        end
        tbl[9] = mk(0, 0,  0, 0, 0,  0,     0, 0, 0,  0,  0, 0, 0);

        // Reset held with an upstream request present: outputs must read 0.
        rst_b = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b1, 5, wd_a);
        tick();
        tick();
        #4 chk("reset_state", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_b = 1'b1;
        idle();
        #4 chk("reset_release", 0, 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].zs, tbl[i].zea, tbl[i].ucs, tbl[i].uwe, tbl[i].ua, tbl[i].uwd);
            #4 chk($sformatf("vec%0d", i), tbl[i].ecs, tbl[i].ewe, tbl[i].ea, tbl[i].ewd,
                   tbl[i].ezip, tbl[i].edone, tbl[i].eblk);
            tick();
        end

        // end=0: single write to word 0, upstream passes during DONE.
        drive(1'b1, 0, 1'b0, 1'b0, 0, 0);
        #4 chk("e0_start", 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        #4 chk("e0_write", 1, 1, 0, 0, 1, 0, 0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b1, 44, wd_a);
        #4 chk("e0_done_pass", 1, 1, 44, wd_a, 1, 1, 0);
        tick();
        idle();
        #4 chk("e0_idle", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Clamp: all-ones end on a 768-word SRAM walks 0..767 then finishes.
        drive(1'b1, all1, 1'b0, 1'b0, 0, 0);
        #4 chk("clamp_start", 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            #4 chk($sformatf("clamp_w%0d", i), 1, 1, AW'(i), 0, 1, 0, 0);
            tick();
        end
        #4 chk("clamp_done", 0, 0, 0, 0, 1, 1, 0);
        tick();
        #4 chk("clamp_idle", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset mid-walk: abandon the walk, no done pulse, next walk restarts at 0.
        drive(1'b1, 3, 1'b0, 1'b0, 0, 0);
        #4 chk("rm_start", 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        #4 chk("rm_w0", 1, 1, 0, 0, 1, 0, 0);
        tick();
        rst_b = 1'b0;
        drive(1'b0, 0, 1'b1, 1'b1, 12, wd_b);
        #4 chk("rm_in_reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_b = 1'b1;
        idle();
        for (int i = 0; i < 5; i++) begin
            #4 chk($sformatf("rm_no_done%0d", i), 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1'b1, 1, 1'b0, 1'b0, 0, 0);
        #4 chk("rm_restart", 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        #4 chk("rm_w0_again", 1, 1, 0, 0, 1, 0, 0);
        tick();
        #4 chk("rm_w1", 1, 1, 1, 0, 1, 0, 0);
        tick();
        #4 chk("rm_done", 0, 0, 0, 0, 1, 1, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
